// File: rtl/program_loader_pkg.sv
// Shared processor package: loader FSM encoding and word-packing constants.
package program_loader_pkg;

    // Loader FSM states: waiting, expecting high byte, expecting low byte, program resident.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } load_state_t;

    // Each instruction word arrives as this many bytes, high byte first.
    localparam int BYTES_PER_WORD = 2;

    // Running checksum update: the checksum is the XOR of every word written.
    function automatic logic [15:0] checksum_fold(input logic [15:0] acc, input logic [15:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/program_loader_ram.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives a processor reset.
module program_ram #(
    parameter int ADDR_W = 3,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data
);

    logic [INST_W-1:0] mem_r [0:(2**ADDR_W)-1];

    // Write the addressed word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles a high-byte-first byte stream into instruction
// words, writes them into the program store and holds the processor until a
// complete program is resident.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data,
    output logic              cpu_hold,
    output logic              prog_valid,
    output logic [ADDR_W-1:0] load_addr,
    output logic [INST_W-1:0] checksum
);

    localparam int BYTE_W = INST_W / BYTES_PER_WORD;

    load_state_t       state_r;
    load_state_t       next_state_s;
    logic [BYTE_W-1:0] hi_byte_r;
    logic [ADDR_W-1:0] load_addr_r;
    logic [INST_W-1:0] checksum_r;
    logic              in_ready_r;
    logic              cpu_hold_r;
    logic              prog_valid_r;
    logic              in_ready_d_s;
    logic              cpu_hold_d_s;
    logic              prog_valid_d_s;
    logic              xfer_s;
    logic              start_s;
    logic              lo_xfer_s;
    logic              last_word_s;
    logic [INST_W-1:0] word_s;

    assign xfer_s      = in_valid & in_ready_r;
    assign start_s     = load_start & ((state_r == IDLE) | (state_r == DONE));
    assign lo_xfer_s   = (state_r == LO) & xfer_s;
    assign last_word_s = (load_addr_r == {ADDR_W{1'b1}});
    assign word_s      = {hi_byte_r, in_data};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; load_start only counts outside an active load.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (load_start) next_state_s = HI;   else next_state_s = IDLE;
            HI:      if (xfer_s)     next_state_s = LO;   else next_state_s = HI;
            LO: begin
                if (xfer_s) begin
                    if (last_word_s) next_state_s = DONE;
                    else             next_state_s = HI;
                end else begin
                    next_state_s = LO;
                end
            end
            DONE:    if (load_start) next_state_s = HI;   else next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the status outputs can be registered.
    always_comb begin
        in_ready_d_s   = 1'b0;
        cpu_hold_d_s   = 1'b1;
        prog_valid_d_s = 1'b0;
        case (next_state_s)
            IDLE:    begin in_ready_d_s = 1'b0; cpu_hold_d_s = 1'b1; prog_valid_d_s = 1'b0; end
            HI:      begin in_ready_d_s = 1'b1; cpu_hold_d_s = 1'b1; prog_valid_d_s = 1'b0; end
            LO:      begin in_ready_d_s = 1'b1; cpu_hold_d_s = 1'b1; prog_valid_d_s = 1'b0; end
            DONE:    begin in_ready_d_s = 1'b0; cpu_hold_d_s = 1'b0; prog_valid_d_s = 1'b1; end
            default: begin in_ready_d_s = 1'b0; cpu_hold_d_s = 1'b1; prog_valid_d_s = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            cpu_hold_r   <= 1'b1;
            prog_valid_r <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_d_s;
            cpu_hold_r   <= cpu_hold_d_s;
            prog_valid_r <= prog_valid_d_s;
        end
    end

    // Load datapath: high-byte capture, write pointer and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte_r   <= {BYTE_W{1'b0}};
            load_addr_r <= {ADDR_W{1'b0}};
            checksum_r  <= {INST_W{1'b0}};
        end else if (start_s) begin
            load_addr_r <= {ADDR_W{1'b0}};
            checksum_r  <= {INST_W{1'b0}};
        end else if (lo_xfer_s) begin
            // The pointer wraps to 0 naturally after the last word.
            load_addr_r <= load_addr_r + ADDR_W'(1);
            checksum_r  <= checksum_fold(checksum_r, word_s);
        end else if ((state_r == HI) && xfer_s) begin
            hi_byte_r <= in_data;
        end
    end

    program_ram #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_ram (
        .clk     (clk),
        .we      (lo_xfer_s),
        .wr_addr (load_addr_r),
        .wr_data (word_s),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign in_ready   = in_ready_r;
    assign cpu_hold   = cpu_hold_r;
    assign prog_valid = prog_valid_r;
    assign load_addr  = load_addr_r;
    assign checksum   = checksum_r;

endmodule
